// File: rtl/instr_fetch_unit.sv
// Fetch stage of the multicycle MIPS core: one word read per fetch_req, result held in IR.
// Optional build macro FETCH_BYTESWAP_EN byte-reverses the returned word (little-endian memory).
module instr_fetch_unit #(
   parameter logic [31:0] HALT_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_req,
   input  logic [31:0] pc_address,
   output logic [31:0] mem_address,
   output logic        mem_read,
   output logic [3:0]  mem_byteenable,
   input  logic        mem_waitrequest,
   input  logic [31:0] mem_readdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        fetch_done,
   output logic        busy,
   output logic        halted,
   output logic        proto_err,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic [15:0] offset,
   output logic [25:0] instr_index
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DATA,
      S_HALTED
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic        w_mem_read;
   logic        w_start;
   logic        w_halt;
   logic        w_capture;
   logic        w_proto;

   logic [31:0] r_mem_address;
   logic [31:0] r_instr;
   logic        r_instr_valid;
   logic        r_fetch_done;
   logic        r_halted;
   logic        r_proto_err;

   function automatic logic [31:0] fetch_word(input logic [31:0] rdata);
`ifdef FETCH_BYTESWAP_EN
      return {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]};
`else
      return rdata;
`endif
   endfunction

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_mem_read   = 1'b0;
      w_start      = 1'b0;
      w_halt       = 1'b0;
      w_capture    = 1'b0;
      w_proto      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (fetch_req) begin
               if (pc_address == HALT_ADDR) begin
                  w_next_state = S_HALTED;
                  w_halt       = 1'b1;
               end else begin
                  w_next_state = S_REQ;
                  w_start      = 1'b1;
               end
            end
         end
         S_REQ: begin
            w_mem_read = 1'b1;
            w_proto    = fetch_req;
            if (!mem_waitrequest) w_next_state = S_DATA;
         end
         S_DATA: begin
            w_capture    = 1'b1;
            w_proto      = fetch_req;
            w_next_state = S_IDLE;
         end
         S_HALTED: w_next_state = S_HALTED;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // Reset clears IR to a NOP and abandons any outstanding read.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem_address <= 32'h0;
         r_instr       <= 32'h0;
         r_instr_valid <= 1'b0;
         r_fetch_done  <= 1'b0;
         r_halted      <= 1'b0;
         r_proto_err   <= 1'b0;
      end else begin
         if (w_start) begin
            r_mem_address <= pc_address;
            r_instr_valid <= 1'b0;
         end
         if (w_capture) begin
            r_instr       <= fetch_word(mem_readdata);
            r_instr_valid <= 1'b1;
         end
         r_fetch_done <= w_capture;
         if (w_halt)  r_halted    <= 1'b1;
         if (w_proto) r_proto_err <= 1'b1;
      end
   end

   assign mem_address    = r_mem_address;
   assign mem_read       = w_mem_read;
   assign mem_byteenable = 4'b1111;
   assign instr          = r_instr;
   assign instr_valid    = r_instr_valid;
   assign fetch_done     = r_fetch_done;
   assign busy           = (r_state == S_REQ) || (r_state == S_DATA);
   assign halted         = r_halted;
   assign proto_err      = r_proto_err;

   assign opcode      = r_instr[31:26];
   assign rs          = r_instr[25:21];
   assign rt          = r_instr[20:16];
   assign rd          = r_instr[15:11];
   assign shamt       = r_instr[10:6];
   assign funct       = r_instr[5:0];
   assign offset      = r_instr[15:0];
   assign instr_index = r_instr[25:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; expected values are hand-computed per step.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_req;
   logic [31:0] pc_address;
   logic [31:0] mem_address;
   logic        mem_read;
   logic [3:0]  mem_byteenable;
   logic        mem_waitrequest;
   logic [31:0] mem_readdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        fetch_done;
   logic        busy;
   logic        halted;
   logic        proto_err;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [15:0] offset;
   logic [25:0] instr_index;

   int n_checks = 0;
   int n_errors = 0;
   int n_acc    = 0;
   int acc_base;

`ifdef FETCH_BYTESWAP_EN
   localparam logic [31:0] RD_T1  = 32'h0A00_0824;
   localparam logic [31:0] EXP_T3 = 32'h2408_000A;
`else
   localparam logic [31:0] RD_T1  = 32'h2408_000A;
   localparam logic [31:0] EXP_T3 = 32'h0A00_0824;
`endif

   instr_fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .fetch_req      (fetch_req),
      .pc_address     (pc_address),
      .mem_address    (mem_address),
      .mem_read       (mem_read),
      .mem_byteenable (mem_byteenable),
      .mem_waitrequest(mem_waitrequest),
      .mem_readdata   (mem_readdata),
      .instr          (instr),
      .instr_valid    (instr_valid),
      .fetch_done     (fetch_done),
      .busy           (busy),
      .halted         (halted),
      .proto_err      (proto_err),
      .opcode         (opcode),
      .rs             (rs),
      .rt             (rt),
      .rd             (rd),
      .shamt          (shamt),
      .funct          (funct),
      .offset         (offset),
      .instr_index    (instr_index)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_read && !mem_waitrequest) n_acc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   initial begin
      reset           = 1'b1;
      fetch_req       = 1'b0;
      pc_address      = 32'h0;
      mem_waitrequest = 1'b0;
      mem_readdata    = 32'h0;
      step();
      step();
      reset = 1'b0;

      // reset state
      chk("rst_instr", instr, 32'h0);
      chk("rst_valid", {31'b0, instr_valid}, 32'h0);
      chk("rst_done", {31'b0, fetch_done}, 32'h0);
      chk("rst_halted", {31'b0, halted}, 32'h0);
      chk("rst_proto", {31'b0, proto_err}, 32'h0);
      chk("rst_mread", {31'b0, mem_read}, 32'h0);
      chk("rst_maddr", mem_address, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("byteen", {28'b0, mem_byteenable}, 32'hF);

      // test 1: zero wait states
      acc_base     = n_acc;
      pc_address   = 32'hBFC0_0000;
      mem_readdata = RD_T1;
      fetch_req    = 1'b1;
      step();  // N+1
      fetch_req = 1'b0;
      chk("t1_mread_n1", {31'b0, mem_read}, 32'h1);
      chk("t1_addr_n1", mem_address, 32'hBFC0_0000);
      chk("t1_busy_n1", {31'b0, busy}, 32'h1);
      step();  // N+2
      chk("t1_mread_n2", {31'b0, mem_read}, 32'h0);
      chk("t1_done_n2", {31'b0, fetch_done}, 32'h0);
      step();  // N+3
      chk("t1_done_n3", {31'b0, fetch_done}, 32'h1);
      chk("t1_valid", {31'b0, instr_valid}, 32'h1);
      chk("t1_instr", instr, 32'h2408_000A);
      chk("t1_opcode", {26'b0, opcode}, 32'h09);
      chk("t1_rs", {27'b0, rs}, 32'h0);
      chk("t1_rt", {27'b0, rt}, 32'h8);
      chk("t1_offset", {16'b0, offset}, 32'h000A);
      chk("t1_index", {6'b0, instr_index}, 32'h0008_000A);
      chk("t1_busy_n3", {31'b0, busy}, 32'h0);
      step();  // N+4
      chk("t1_done_n4", {31'b0, fetch_done}, 32'h0);
      chk("t1_hold", instr, 32'h2408_000A);
      chk("t1_reads", n_acc - acc_base, 32'h1);

      // test 2: three wait states
      pc_address      = 32'h0040_0010;
      mem_readdata    = 32'h8C82_0004;
      mem_waitrequest = 1'b1;
      fetch_req       = 1'b1;
      step();  // N+1
      fetch_req  = 1'b0;
      pc_address = 32'h1234_5678;
      chk("t2_valid_low", {31'b0, instr_valid}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) mem_waitrequest = 1'b0;
         chk("t2_mread_hold", {31'b0, mem_read}, 32'h1);
         chk("t2_addr_hold", mem_address, 32'h0040_0010);
         chk("t2_done_low", {31'b0, fetch_done}, 32'h0);
         step();
      end
      // now N+5
      chk("t2_mread_n5", {31'b0, mem_read}, 32'h0);
      chk("t2_done_n5", {31'b0, fetch_done}, 32'h0);
      step();  // N+6
      chk("t2_done_n6", {31'b0, fetch_done}, 32'h1);
`ifdef FETCH_BYTESWAP_EN
      chk("t2_instr", instr, 32'h0400_828C);
`else
      chk("t2_instr", instr, 32'h8C82_0004);
      chk("t2_rs", {27'b0, rs}, 32'h4);
      chk("t2_rt", {27'b0, rt}, 32'h2);
`endif
      step();

      // test 3: byte ordering of the captured word
      pc_address   = 32'h0000_0100;
      mem_readdata = 32'h0A00_0824;
      fetch_req    = 1'b1;
      step();
      fetch_req = 1'b0;
      step();
      step();
      chk("t3_done", {31'b0, fetch_done}, 32'h1);
      chk("t3_instr", instr, EXP_T3);
      step();

      // test 5: fetch_req while busy
      acc_base     = n_acc;
      pc_address   = 32'h0000_0200;
      mem_readdata = 32'h0000_0020;
      fetch_req    = 1'b1;
      step();  // N+1, still requesting
      pc_address = 32'h0000_0300;
      chk("t5_proto_n1", {31'b0, proto_err}, 32'h0);
      step();  // N+2
      fetch_req = 1'b0;
      chk("t5_proto_n2", {31'b0, proto_err}, 32'h1);
      chk("t5_mread_n2", {31'b0, mem_read}, 32'h0);
      step();  // N+3
      chk("t5_done", {31'b0, fetch_done}, 32'h1);
      chk("t5_instr", instr, 32'h0000_0020);
      chk("t5_funct", {26'b0, funct}, 32'h20);
      chk("t5_addr", mem_address, 32'h0000_0200);
      step();
      step();
      chk("t5_idle_mread", {31'b0, mem_read}, 32'h0);
      chk("t5_reads", n_acc - acc_base, 32'h1);
      chk("t5_proto_sticky", {31'b0, proto_err}, 32'h1);

      // test 6: reset during a stalled read
      pc_address      = 32'h0000_0400;
      mem_readdata    = 32'hFFFF_FFFF;
      mem_waitrequest = 1'b1;
      fetch_req       = 1'b1;
      step();
      fetch_req = 1'b0;
      chk("t6_mread_req", {31'b0, mem_read}, 32'h1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t6_mread", {31'b0, mem_read}, 32'h0);
      chk("t6_instr", instr, 32'h0);
      chk("t6_valid", {31'b0, instr_valid}, 32'h0);
      chk("t6_proto", {31'b0, proto_err}, 32'h0);
      chk("t6_addr", mem_address, 32'h0);
      mem_waitrequest = 1'b0;
      pc_address      = 32'h0000_0500;
      mem_readdata    = 32'h0000_000C;
      fetch_req       = 1'b1;
      step();
      fetch_req = 1'b0;
      chk("t6_refetch_mread", {31'b0, mem_read}, 32'h1);
      step();
      step();
      chk("t6_refetch_done", {31'b0, fetch_done}, 32'h1);
      chk("t6_refetch_instr", instr, 32'h0000_000C);
      step();

      // test 4: halt address
      acc_base   = n_acc;
      pc_address = 32'h0000_0000;
      fetch_req  = 1'b1;
      step();  // N+1
      fetch_req = 1'b0;
      chk("t4_halted", {31'b0, halted}, 32'h1);
      chk("t4_mread", {31'b0, mem_read}, 32'h0);
      chk("t4_busy", {31'b0, busy}, 32'h0);
      pc_address = 32'hBFC0_0000;
      fetch_req  = 1'b1;
      step();
      fetch_req = 1'b0;
      chk("t4_ignored_mread", {31'b0, mem_read}, 32'h0);
      step();
      step();
      chk("t4_no_done", {31'b0, fetch_done}, 32'h0);
      chk("t4_instr_held", instr, 32'h0000_000C);
      chk("t4_still_halted", {31'b0, halted}, 32'h1);
      chk("t4_proto", {31'b0, proto_err}, 32'h0);
      chk("t4_reads", n_acc - acc_base, 32'h0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t4_reset_clears", {31'b0, halted}, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
